// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared constants, defaults and next-pc source encoding for pc_gen
//
// Purpose : common enable/stop/branch levels, parameter defaults, the
//           next-pc source enumeration and the alignment helper.
// Ports   : none (package).
package pc_gen_pkg;

    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;
    localparam logic NOT_STOP = 1'b0;
    localparam logic BRANCH   = 1'b1;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          STEP_DEF     = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Which source feeds the next pc; listed highest priority first.
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_FLUSH,
        SRC_BRANCH,
        SRC_DEFER,
        SRC_PEND,
        SRC_RAS,
        SRC_SEQ
    } pc_src_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-side bus between pc_gen and the instruction memory / if_id
//
// Purpose : carries the fetch address, its enable and alignment flag out,
//           and the memory's acceptance back.
// Signals : pc, ce, pc_misaligned (generator -> memory), fetch_ready (memory -> generator).
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              pc_misaligned;
    logic              fetch_ready;

    modport master (
        output pc,
        output ce,
        output pc_misaligned,
        input  fetch_ready
    );

    modport slave (
        input  pc,
        input  ce,
        input  pc_misaligned,
        output fetch_ready
    );
endinterface

// File: rtl/pc_gen_ras.sv
// rtl/pc_gen_ras.sv - circular return-address stack with saturating count
//
// Purpose : return-address prediction storage. A push when full overwrites
//           the oldest entry; push together with pop replaces the top entry.
// Ports   : clk, reset (sync, active-high), clear, push, pop, push_addr,
//           top (current top entry), empty, full.
import pc_gen_pkg::*;

module pc_ras #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_pop;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_ptr;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign top    = mem_q[top_q];
    assign do_pop = pop & ~empty;

    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = top_q;
        if (clear) begin
            cnt_d = '0;
        end else if (push && do_pop) begin
            // Old top is consumed and the new return address takes its slot.
            wr_en = 1'b1;
        end else if (push) begin
            // DEPTH is a power of two, so the pointer wraps naturally and
            // the slot after the top is the oldest entry when full.
            top_d  = top_q + PTR_W'(1);
            wr_ptr = top_q + PTR_W'(1);
            wr_en  = 1'b1;
            if (!full) cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem_q[wr_ptr] <= push_addr;
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator with redirects and RAS prediction
//
// Purpose : picks the next fetch address from flush, branch, deferred branch,
//           return-address stack and sequential step, in that priority.
// Ports   : clk, reset (sync, active-high), stall_if, flush/flush_pc,
//           branch_flag/branch_target, ras_push/ras_push_addr, ras_pop,
//           redirect_pending, ras_empty, fetch (pc_gen_if master: pc, ce,
//           pc_misaligned, fetch_ready).
import pc_gen_pkg::*;

module pc_gen #(
    parameter int              ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int              STEP      = STEP_DEF,
    parameter int              RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_if,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              ras_push,
    input  logic [ADDR_W-1:0] ras_push_addr,
    input  logic              ras_pop,
    output logic              redirect_pending,
    output logic              ras_empty,
    pc_gen_if.master          fetch
);
    logic              ce_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              adv;
    pc_src_e           src;

    logic [ADDR_W-1:0] ras_top;
    logic              ras_do_push;
    logic              ras_do_pop;
    logic              ras_clear;

    assign adv = ce_q & (stall_if == NOT_STOP) & fetch.fetch_ready;

    always_comb begin
        src = SRC_HOLD;
        if (ce_q) begin
            if (flush)                                src = SRC_FLUSH;
            else if (branch_flag == BRANCH)           src = adv ? SRC_BRANCH : SRC_DEFER;
            else if (pend_q && adv)                   src = SRC_PEND;
            else if (ras_pop && adv && !ras_empty)    src = SRC_RAS;
            else if (adv)                             src = SRC_SEQ;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        case (src)
            SRC_FLUSH: begin
                pc_d   = flush_pc;
                pend_d = 1'b0;
            end
            SRC_BRANCH: begin
                pc_d   = branch_target;
                pend_d = 1'b0;
            end
            SRC_DEFER: begin
                // Fetch is held: remember the target, newest branch wins.
                pend_pc_d = branch_target;
                pend_d    = 1'b1;
            end
            SRC_PEND: begin
                pc_d   = pend_pc_q;
                pend_d = 1'b0;
            end
            SRC_RAS:   pc_d = ras_top;
            SRC_SEQ:   pc_d = pc_q + ADDR_W'(STEP);
            default:   ;
        endcase
    end

    assign ras_do_push = ras_push & ce_q & ~flush;
    assign ras_do_pop  = (src == SRC_RAS);
    assign ras_clear   = ce_q & flush;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (ras_clear),
        .push      (ras_do_push),
        .pop       (ras_do_pop),
        .push_addr (ras_push_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      ()
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ce_q      <= DISABLE;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            ce_q      <= ENABLE;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign fetch.pc            = pc_q;
    assign fetch.ce            = ce_q;
    assign fetch.pc_misaligned = is_misaligned(pc_q[1:0]);
    assign redirect_pending    = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen against a queue-based reference model
module tb_pc_gen;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_if = 1'b0;
    logic        fetch_ready = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        ras_push = 1'b0;
    logic [31:0] ras_push_addr = '0;
    logic        ras_pop = 1'b0;
    logic        redirect_pending;
    logic        ras_empty;

    int checks = 0;
    int errors = 0;

    pc_gen_if #(.ADDR_W(32)) fif ();
    assign fif.fetch_ready = fetch_ready;

    pc_gen #(.ADDR_W(32), .RESET_PC(RST_PC), .STEP(4), .RAS_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_if         (stall_if),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .branch_flag      (branch_flag),
        .branch_target    (branch_target),
        .ras_push         (ras_push),
        .ras_push_addr    (ras_push_addr),
        .ras_pop          (ras_pop),
        .redirect_pending (redirect_pending),
        .ras_empty        (ras_empty),
        .fetch            (fif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: architectural state plus the stack as a plain queue
    // (back = top, front = oldest).
    bit          m_valid = 0;
    bit          m_ce;
    logic [31:0] m_pc;
    bit          m_rp;
    logic [31:0] m_pend;
    logic [31:0] m_stk [$];

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("ce", {31'b0, fif.ce}, {31'b0, m_ce});
                chk("pc", fif.pc, m_pc);
                chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_rp});
                chk("ras_empty", {31'b0, ras_empty}, {31'b0, m_stk.size() == 0});
                chk("pc_misaligned", {31'b0, fif.pc_misaligned}, {31'b0, m_pc % 4 != 0});
            end
            if (reset) begin
                m_valid = 1;
                m_ce    = 0;
                m_pc    = RST_PC;
                m_rp    = 0;
                m_stk.delete();
            end else if (m_valid) begin
                if (!m_ce) begin
                    m_ce = 1;
                end else begin
                    bit adv;
                    adv = !stall_if && fetch_ready;
                    if (flush) begin
                        m_pc = flush_pc;
                        m_rp = 0;
                        m_stk.delete();
                    end else begin
                        if (branch_flag) begin
                            if (adv) begin m_pc = branch_target; m_rp = 0; end
                            else begin m_pend = branch_target; m_rp = 1; end
                        end else if (m_rp && adv) begin
                            m_pc = m_pend;
                            m_rp = 0;
                        end else if (ras_pop && adv && m_stk.size() > 0) begin
                            m_pc = m_stk.pop_back();
                        end else if (adv) begin
                            m_pc = m_pc + 32'd4;
                        end
                        if (ras_push) begin
                            m_stk.push_back(ras_push_addr);
                            if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_if = 0; fetch_ready = 1; flush = 0; branch_flag = 0;
        ras_push = 0; ras_pop = 0;
    endtask

    initial begin
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h50; exp_pc[1] = 32'h40; exp_pc[2] = 32'h30; exp_pc[3] = 32'h20;

        // Reset and first fetches.
        idle();
        reset = 1;
        tick(); tick();
        chk("rst_ce", {31'b0, fif.ce}, 32'h0);
        chk("rst_pc", fif.pc, 32'h0);
        chk("rst_rp", {31'b0, redirect_pending}, 32'h0);
        chk("rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("rst_mis", {31'b0, fif.pc_misaligned}, 32'h0);
        reset = 0;
        tick();
        chk("first_ce", {31'b0, fif.ce}, 32'h1);
        chk("first_pc", fif.pc, 32'h0);
        tick(); chk("seq_4", fif.pc, 32'h4);
        tick(); chk("seq_8", fif.pc, 32'h8);
        tick(); chk("seq_c", fif.pc, 32'hC);

        // Branch arriving during a stall is deferred, then taken.
        stall_if = 1;
        tick();
        branch_flag = 1; branch_target = 32'h100;
        tick();
        chk("stall_pc", fif.pc, 32'hC);
        chk("stall_rp", {31'b0, redirect_pending}, 32'h1);
        branch_flag = 0;
        tick();
        chk("stall3_pc", fif.pc, 32'hC);
        stall_if = 0;
        tick();
        chk("defer_pc", fif.pc, 32'h100);
        chk("defer_rp", {31'b0, redirect_pending}, 32'h0);

        // Flush beats a simultaneous branch under stall.
        stall_if = 1; flush = 1; flush_pc = 32'h80; branch_flag = 1; branch_target = 32'h200;
        tick();
        chk("flush_pc", fif.pc, 32'h80);
        chk("flush_rp", {31'b0, redirect_pending}, 32'h0);
        chk("flush_empty", {31'b0, ras_empty}, 32'h1);
        idle();

        // Five pushes into a 4-deep stack, then five pops.
        for (int i = 1; i <= 5; i++) begin
            ras_push = 1; ras_push_addr = 32'(i * 16);
            tick();
        end
        ras_push = 0; ras_pop = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ras_pop", fif.pc, exp_pc[i]);
        end
        tick();
        chk("ras_fall_pc", fif.pc, 32'h24);
        chk("ras_fall_empty", {31'b0, ras_empty}, 32'h1);
        ras_pop = 0;

        // Wrap and misalignment.
        branch_flag = 1; branch_target = 32'hFFFF_FFFC;
        tick(); chk("wrap_top", fif.pc, 32'hFFFF_FFFC);
        branch_flag = 0;
        tick(); chk("wrap_zero", fif.pc, 32'h0);
        branch_flag = 1; branch_target = 32'h102;
        tick();
        chk("mis_pc", fif.pc, 32'h102);
        chk("mis_flag", {31'b0, fif.pc_misaligned}, 32'h1);
        branch_target = 32'h200;
        tick();
        chk("mis_clear", {31'b0, fif.pc_misaligned}, 32'h0);
        branch_flag = 0;

        // Reset mid-operation with a pending redirect and three stacked entries.
        for (int i = 0; i < 3; i++) begin
            ras_push = 1; ras_push_addr = 32'h1000 + 32'(i * 4);
            tick();
        end
        ras_push = 0;
        stall_if = 1; branch_flag = 1; branch_target = 32'h300;
        tick();
        chk("pre_rst_rp", {31'b0, redirect_pending}, 32'h1);
        chk("pre_rst_empty", {31'b0, ras_empty}, 32'h0);
        reset = 1; flush = 1; flush_pc = 32'h500;
        tick();
        chk("mid_rst_pc", fif.pc, RST_PC);
        chk("mid_rst_ce", {31'b0, fif.ce}, 32'h0);
        chk("mid_rst_rp", {31'b0, redirect_pending}, 32'h0);
        chk("mid_rst_empty", {31'b0, ras_empty}, 32'h1);
        reset = 0;
        idle();

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 299) == 0);
            stall_if      = ($urandom_range(0, 3) == 0);
            fetch_ready   = ($urandom_range(0, 4) != 0);
            flush         = ($urandom_range(0, 24) == 0);
            flush_pc      = $urandom() & 32'hFFFF_FFFC;
            branch_flag   = ($urandom_range(0, 7) == 0);
            branch_target = ($urandom_range(0, 9) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            ras_push      = ($urandom_range(0, 3) == 0);
            ras_push_addr = $urandom() & 32'hFFFF_FFFC;
            ras_pop       = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 0;
        idle();
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage, replacing the fixed single-step PC register.
- Selects the next fetch address from these sources, in priority order:
  1. flush/exception redirect
  2. branch redirect
  3. branch redirect deferred during a stall
  4. return-address-stack prediction
  5. sequential increment
- A redirect that arrives while fetch is held is never lost.
- Drives pc/ce to the instruction memory and if_id.

Parameters:
- ADDR_W, 32, PC and target width.
- RESET_PC, 32'h00000000, fetch address after reset.
- STEP, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address-stack entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall_if  in  1  hold PC (hazard stall, stall bit 0).
- fetch_ready  in  1  instruction memory accepts the current pc.
- flush  in  1  exception/flush redirect.
- flush_pc  in  ADDR_W  flush target.
- branch_flag  in  1  resolved branch taken.
- branch_target  in  ADDR_W  branch target.
- ras_push  in  1  call decoded; push ras_push_addr.
- ras_push_addr  in  ADDR_W  return address.
- ras_pop  in  1  return predicted at current pc.
- pc  out  ADDR_W  fetch address.
- ce  out  1  fetch enable.
- redirect_pending  out  1  deferred branch is held.
- ras_empty  out  1  stack empty.
- pc_misaligned  out  1  pc[1:0] != 0.

Behaviour:
- Reset (synchronous, active-high, on clk):
  - ce=0, pc=RESET_PC, redirect_pending=0, RAS count=0, ras_empty=1, pc_misaligned = misalignment of RESET_PC.
- While ce=0, pc holds RESET_PC.
- ce rises one cycle after reset deasserts. The first fetch address is RESET_PC (no skip).
- adv = ce & ~stall_if & fetch_ready.
- Next-pc priority, evaluated each cycle with ce=1:
  1. flush: pc<=flush_pc regardless of adv. Clears the pending redirect. Clears the RAS (count=0).
  2. else branch_flag & adv: pc<=branch_target. Clears the pending redirect.
  3. else branch_flag & ~adv: pc holds; pend_pc<=branch_target; redirect_pending<=1. A newer branch overwrites an older pending one.
  4. else redirect_pending & adv: pc<=pend_pc; redirect_pending<=0.
  5. else ras_pop & adv & ~ras_empty: pc<=top of stack; pop.
  6. else adv: pc<=pc+STEP, modulo 2^ADDR_W (wraps from all-ones−STEP+1 to 0).
  7. else: hold.
- Redirect latency: 1 cycle from a sampled redirect to the new pc.
- RAS:
  - Circular buffer with top pointer and saturating count.
  - Push when ras_push & ce & ~flush.
  - Push while full overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop on empty: no pop; sequential path is taken.
  - Push and a qualifying pop in the same cycle: the top entry is replaced by ras_push_addr; count unchanged. pc takes the old top.
  - Pop is suppressed when a higher-priority redirect wins; stack unchanged.
- pc_misaligned is combinational from pc. No trap is raised here; the exception unit consumes the flag.
- Reset mid-operation dominates every other input, including flush.

Decomposition:
- The shared defines file gains: Enable/Disable, NotStop, Branch, ADDR_W default, STEP default, RESET_PC default.
- One sub-module, pc_ras: parametrised circular return-address stack. Ports: push, pop, push_addr, top, empty, full, clear.

Test Plan:
- Reset released at cycle 0, no stall, ready=1 -> ce=1 at cycle 1, pc sequence 0,0,4,8,C.
- stall_if=1 for 3 cycles with branch_flag pulsed in the 2nd stalled cycle to 0x100 -> pc held, redirect_pending=1; first cycle after stall clears, pc=0x100 and redirect_pending=0.
- flush=1 (flush_pc=0x80) with branch_flag=1 (target 0x200) and stall_if=1 -> pc=0x80 next cycle, redirect_pending=0, ras_empty=1.
- Push 0x10,0x20,0x30,0x40,0x50 with RAS_DEPTH=4, then 5 pops -> pc 0x50,0x40,0x30,0x20, then the 5th pop falls through to pc+4 with ras_empty=1.
- pc=32'hFFFFFFFC, adv -> pc=0. branch_target=0x102 -> pc_misaligned=1.
- Assert reset while redirect_pending=1 and RAS count=3 -> next cycle pc=RESET_PC, ce=0, redirect_pending=0, ras_empty=1.
